// File: rtl/ahblite_pkg.sv
// ahblite_pkg: definitions shared by the AHB-Lite matrix blocks.
//   - slot geometry: 16 slave slots, decoded from HADDR[31:28]
//   - HTRANS / HRESP encodings
//   - slot_decode(): address -> one-hot slot vector
package ahblite_pkg;

  localparam int NUM_SLOTS = 16;
  localparam int SLOT_MSB  = 31;
  localparam int SLOT_LSB  = 28;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // One-hot slot vector for an address; enable masking is left to the caller.
  function automatic logic [NUM_SLOTS-1:0] slot_decode(input logic [31:0] addr);
    logic [NUM_SLOTS-1:0] oh;
    oh = '0;
    oh[addr[SLOT_MSB:SLOT_LSB]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave: answers an unmapped address phase with the
// two-cycle AHB ERROR response (ERR1: wait + ERROR, ERR2: ready + ERROR).
//   HCLK, HRESETN  clock, synchronous active-low reset
//   start          unmapped active transfer accepted this cycle
//   hready, hresp  data-phase ready / response of the default slave
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETN,
  input  logic start,
  output logic hready,
  output logic hresp
);

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [1:0] state_q, state_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = DS_IDLE;
    case (state_q)
      DS_IDLE: state_d = start ? DS_ERR1 : DS_IDLE;
      DS_ERR1: state_d = DS_ERR2;
      // ERR2 completes the error, so the master may already issue a new
      // (possibly again unmapped) address in this cycle.
      DS_ERR2: state_d = start ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (!HRESETN) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  assign hready = (state_q != DS_ERR1);
  assign hresp  = (state_q != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahblite_master_stage.sv
// ahblite_master_stage: per-master front end of the 4x16 AHB-Lite matrix.
//   HADDR_M..HMASTLOCK_M, HWDATA_M  master address/data phase inputs
//   HREADY_M, HRESP_M, HRDATA_M     responses back to the master
//   GATEDH*, GATEDHWDATA            address/control/data to all slave stages
//   SADDRSEL / SDATASEL             one-hot address- / data-phase slot selects
//   SPREVDATASLAVEREADY             copy of HREADY_M for the slave stages
//   SADDRREADY, SDATAREADY, SHRESP  per-slot grant / ready / response
//   HRDATA_S                        per-slot read data, slot s at [32s+31:32s]
// A mapped address not granted by its slave stage is parked in hold
// registers and the master is stalled until the grant arrives.
module ahblite_master_stage
  import ahblite_pkg::*;
#(
  parameter logic [NUM_SLOTS-1:0] SLAVE_EN = 16'hFFFF
) (
  input  logic                   HCLK,
  input  logic                   HRESETN,
  input  logic [31:0]            HADDR_M,
  input  logic [1:0]             HTRANS_M,
  input  logic [2:0]             HSIZE_M,
  input  logic [2:0]             HBURST_M,
  input  logic                   HWRITE_M,
  input  logic                   HMASTLOCK_M,
  input  logic [31:0]            HWDATA_M,
  output logic                   HREADY_M,
  output logic                   HRESP_M,
  output logic [31:0]            HRDATA_M,
  output logic [31:0]            GATEDHADDR,
  output logic [1:0]             GATEDHTRANS,
  output logic [2:0]             GATEDHSIZE,
  output logic [2:0]             GATEDHBURST,
  output logic                   GATEDHWRITE,
  output logic                   GATEDHMASTLOCK,
  output logic [31:0]            GATEDHWDATA,
  output logic [NUM_SLOTS-1:0]   SADDRSEL,
  output logic [NUM_SLOTS-1:0]   SDATASEL,
  output logic                   SPREVDATASLAVEREADY,
  input  logic [NUM_SLOTS-1:0]   SADDRREADY,
  input  logic [NUM_SLOTS-1:0]   SDATAREADY,
  input  logic [NUM_SLOTS-1:0]   SHRESP,
  input  logic [32*NUM_SLOTS-1:0] HRDATA_S
);

  logic                 held_q, held_d;
  logic [NUM_SLOTS-1:0] data_sel_q, data_sel_d;
  logic [31:0]          addr_q;
  logic [1:0]           trans_q;
  logic [2:0]           size_q, burst_q;
  logic                 write_q, lock_q;

  logic [NUM_SLOTS-1:0] sel_oh, grant;
  logic                 active, mapped, any_grant, capture, ds_start;
  logic                 dp_ready, dp_resp, ds_hready, ds_hresp, hready;
  logic [31:0]          rdata;

  // Address source: the parked address while held, otherwise the live master bus.
  assign GATEDHADDR     = held_q ? addr_q  : HADDR_M;
  assign GATEDHTRANS    = held_q ? trans_q : HTRANS_M;
  assign GATEDHSIZE     = held_q ? size_q  : HSIZE_M;
  assign GATEDHBURST    = held_q ? burst_q : HBURST_M;
  assign GATEDHWRITE    = held_q ? write_q : HWRITE_M;
  assign GATEDHMASTLOCK = held_q ? lock_q  : HMASTLOCK_M;
  assign GATEDHWDATA    = HWDATA_M;

  assign sel_oh = slot_decode(GATEDHADDR) & SLAVE_EN;
  assign mapped = |sel_oh;
  assign active = GATEDHTRANS[1];

  // Data-phase mux driven by the one-hot data select (zero when no data phase).
  always_comb begin
    rdata    = '0;
    dp_ready = 1'b0;
    dp_resp  = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (data_sel_q[s]) begin
        rdata    = rdata | HRDATA_S[32*s +: 32];
        dp_ready = dp_ready | SDATAREADY[s];
        dp_resp  = dp_resp | SHRESP[s];
      end
    end
  end

  assign hready   = (|data_sel_q) ? (dp_ready & ~held_q) : (ds_hready & ~held_q);
  assign HREADY_M = hready;
  assign HRESP_M  = (|data_sel_q) ? dp_resp : ds_hresp;
  assign HRDATA_M = rdata;
  assign SDATASEL = data_sel_q;
  assign SPREVDATASLAVEREADY = hready;

  // Reset gates the select so no slave stage sees a request during reset.
  assign SADDRSEL  = sel_oh & {NUM_SLOTS{active & (held_q | hready) & HRESETN}};
  assign grant     = SADDRSEL & SADDRREADY;
  assign any_grant = |grant;

  // A presented-but-ungranted request is (or stays) held; a fresh one is captured.
  assign held_d   = (|SADDRSEL) & ~any_grant;
  assign capture  = held_d & ~held_q;
  assign ds_start = hready & active & ~mapped;

  always_comb begin
    data_sel_d = data_sel_q;
    if (any_grant)   data_sel_d = sel_oh;
    else if (hready) data_sel_d = '0;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      held_q     <= 1'b0;
      data_sel_q <= '0;
      addr_q     <= '0;
      trans_q    <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      write_q    <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      held_q     <= held_d;
      data_sel_q <= data_sel_d;
      if (capture) begin
        addr_q  <= HADDR_M;
        trans_q <= HTRANS_M;
        size_q  <= HSIZE_M;
        burst_q <= HBURST_M;
        write_q <= HWRITE_M;
        lock_q  <= HMASTLOCK_M;
      end
    end
  end

  ahblite_default_slave u_default_slave (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .start   (ds_start),
    .hready  (ds_hready),
    .hresp   (ds_hresp)
  );

endmodule

// File: tb/tb_ahblite_master_stage.sv
module tb_ahblite_master_stage;
  import ahblite_pkg::*;

  logic         HCLK = 1'b0;
  logic         HRESETN;
  logic [31:0]  HADDR_M, HWDATA_M;
  logic [1:0]   HTRANS_M;
  logic [2:0]   HSIZE_M, HBURST_M;
  logic         HWRITE_M, HMASTLOCK_M;
  logic         HREADY_M, HRESP_M;
  logic [31:0]  HRDATA_M, GATEDHADDR, GATEDHWDATA;
  logic [1:0]   GATEDHTRANS;
  logic [2:0]   GATEDHSIZE, GATEDHBURST;
  logic         GATEDHWRITE, GATEDHMASTLOCK, SPREVDATASLAVEREADY;
  logic [15:0]  SADDRSEL, SDATASEL, SADDRREADY, SDATAREADY, SHRESP;
  logic [511:0] HRDATA_S;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahblite_master_stage #(.SLAVE_EN(16'h7FFF)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M),
    .HWRITE_M(HWRITE_M), .HMASTLOCK_M(HMASTLOCK_M), .HWDATA_M(HWDATA_M),
    .HREADY_M(HREADY_M), .HRESP_M(HRESP_M), .HRDATA_M(HRDATA_M),
    .GATEDHADDR(GATEDHADDR), .GATEDHTRANS(GATEDHTRANS), .GATEDHSIZE(GATEDHSIZE),
    .GATEDHBURST(GATEDHBURST), .GATEDHWRITE(GATEDHWRITE), .GATEDHMASTLOCK(GATEDHMASTLOCK),
    .GATEDHWDATA(GATEDHWDATA), .SADDRSEL(SADDRSEL), .SDATASEL(SDATASEL),
    .SPREVDATASLAVEREADY(SPREVDATASLAVEREADY),
    .SADDRREADY(SADDRREADY), .SDATAREADY(SDATAREADY), .SHRESP(SHRESP), .HRDATA_S(HRDATA_S)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int s);
    return {8'hD5, 8'(s), 16'hC0DE};
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [15:0] oh);
    logic [31:0] r = '0;
    for (int i = 0; i < 16; i++) if (oh[i]) r = pat(i);
    return r;
  endfunction

  // Inputs are applied on the falling edge and outputs sampled 2 time units later.
  task automatic cyc(input logic [31:0] addr, input logic [1:0] trans,
                     input logic [15:0] aready, input logic [15:0] dready);
    @(negedge HCLK);
    HADDR_M = addr; HTRANS_M = trans; SADDRREADY = aready; SDATAREADY = dready;
    #2;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [15:0] aready;
    logic [15:0] dready;
    logic [15:0] resp;
    logic [15:0] e_asel;
    logic [15:0] e_dsel;
    logic        e_ready;
    logic        e_resp;
  } vec_t;

  vec_t vecs[13];
  int   low_cycles;

  initial begin
    vecs[0]  = '{32'h2000_0000, HTRANS_IDLE,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{32'h3000_0010, HTRANS_NONSEQ, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0008, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{32'h0000_0000, HTRANS_IDLE,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0008, 1'b1, 1'b0};
    vecs[3]  = '{32'h1000_0004, HTRANS_NONSEQ, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{32'h1000_0008, HTRANS_SEQ,    16'hFFFF, 16'hFFFF, 16'h0000, 16'h0002, 16'h0002, 1'b1, 1'b0};
    vecs[5]  = '{32'h1000_000C, HTRANS_BUSY,   16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000, 16'h0002, 1'b1, 1'b1};
    vecs[6]  = '{32'h0000_0000, HTRANS_IDLE,   16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{32'hE000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0000, HTRANS_IDLE,   16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000_0000, HTRANS_IDLE,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h4000, 1'b1, 1'b0};
    vecs[10] = '{32'h0000_0000, HTRANS_IDLE,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{32'h0000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{32'h0000_0000, HTRANS_IDLE,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0};

    for (int s = 0; s < 16; s++) HRDATA_S[32*s +: 32] = pat(s);
    HRESETN = 1'b0; HADDR_M = 32'h3000_0000; HTRANS_M = HTRANS_NONSEQ;
    HSIZE_M = 3'b010; HBURST_M = 3'b000; HWRITE_M = 1'b0; HMASTLOCK_M = 1'b0;
    HWDATA_M = 32'hCAFE_F00D; SADDRREADY = 16'hFFFF; SDATAREADY = 16'hFFFF; SHRESP = '0;

    // Reset state: select gated by reset, outputs at idle values, bus follows live inputs.
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); #2;
    check("rst_saddrsel", {16'h0, SADDRSEL}, 32'h0);
    check("rst_sdatasel", {16'h0, SDATASEL}, 32'h0);
    check("rst_hready", {31'h0, HREADY_M}, 32'h1);
    check("rst_hresp", {31'h0, HRESP_M}, 32'h0);
    check("rst_hrdata", HRDATA_M, 32'h0);
    check("rst_gaddr", GATEDHADDR, 32'h3000_0000);
    check("gwdata", GATEDHWDATA, 32'hCAFE_F00D);
    HTRANS_M = HTRANS_IDLE;
    HRESETN = 1'b1;

    // Table: one vector per clock, expected outputs relative to the preceding vectors.
    for (int i = 0; i < 13; i++) begin
      @(negedge HCLK);
      HADDR_M = vecs[i].addr; HTRANS_M = vecs[i].trans;
      SADDRREADY = vecs[i].aready; SDATAREADY = vecs[i].dready; SHRESP = vecs[i].resp;
      #2;
      check($sformatf("v%0d_saddrsel", i), {16'h0, SADDRSEL}, {16'h0, vecs[i].e_asel});
      check($sformatf("v%0d_sdatasel", i), {16'h0, SDATASEL}, {16'h0, vecs[i].e_dsel});
      check($sformatf("v%0d_hready", i), {31'h0, HREADY_M}, {31'h0, vecs[i].e_ready});
      check($sformatf("v%0d_prevready", i), {31'h0, SPREVDATASLAVEREADY}, {31'h0, vecs[i].e_ready});
      check($sformatf("v%0d_hresp", i), {31'h0, HRESP_M}, {31'h0, vecs[i].e_resp});
      check($sformatf("v%0d_gaddr", i), GATEDHADDR, vecs[i].addr);
      check($sformatf("v%0d_hrdata", i), HRDATA_M, exp_rdata(vecs[i].e_dsel));
    end
    SHRESP = '0;

    // Hold: slot 5 write loses arbitration for three cycles.
    @(negedge HCLK);
    HADDR_M = 32'h5000_0000; HTRANS_M = HTRANS_NONSEQ; HWRITE_M = 1'b1;
    HMASTLOCK_M = 1'b1; HSIZE_M = 3'b010; SADDRREADY = ~16'h0020; SDATAREADY = 16'hFFFF;
    #2;
    check("hold_c0_saddrsel", {16'h0, SADDRSEL}, 32'h0020);
    check("hold_c0_hready", {31'h0, HREADY_M}, 32'h1);
    low_cycles = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge HCLK);
      HADDR_M = 32'h6000_0000; HTRANS_M = HTRANS_IDLE; HWRITE_M = 1'b0;
      HMASTLOCK_M = 1'b0; HSIZE_M = 3'b000;
      SADDRREADY = (c == 3) ? 16'hFFFF : ~16'h0020;
      #2;
      if (!HREADY_M) low_cycles++;
      check($sformatf("hold_c%0d_gaddr", c), GATEDHADDR, 32'h5000_0000);
      check($sformatf("hold_c%0d_saddrsel", c), {16'h0, SADDRSEL}, 32'h0020);
    end
    check("hold_gtrans", {30'h0, GATEDHTRANS}, {30'h0, HTRANS_NONSEQ});
    check("hold_gwrite", {31'h0, GATEDHWRITE}, 32'h1);
    check("hold_glock", {31'h0, GATEDHMASTLOCK}, 32'h1);
    check("hold_gsize", {29'h0, GATEDHSIZE}, 32'h2);
    check("hold_sdatasel", {16'h0, SDATASEL}, 32'h0);
    check("hold_low_cycles", low_cycles, 3);
    cyc(32'h6000_0000, HTRANS_IDLE, 16'hFFFF, 16'hFFFF);
    check("hold_after_sdatasel", {16'h0, SDATASEL}, 32'h0020);
    check("hold_after_gaddr", GATEDHADDR, 32'h6000_0000);
    check("hold_after_hready", {31'h0, HREADY_M}, 32'h1);
    check("hold_after_glock", {31'h0, GATEDHMASTLOCK}, 32'h0);

    // Unmapped slot 15 (disabled): ERR1 then ERR2, new mapped access during ERR2.
    cyc(32'hF000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'hFFFF);
    check("err_c0_saddrsel", {16'h0, SADDRSEL}, 32'h0);
    check("err_c0_hready", {31'h0, HREADY_M}, 32'h1);
    cyc(32'h0000_0000, HTRANS_IDLE, 16'hFFFF, 16'hFFFF);
    check("err1_hready", {31'h0, HREADY_M}, 32'h0);
    check("err1_hresp", {31'h0, HRESP_M}, 32'h1);
    check("err1_saddrsel", {16'h0, SADDRSEL}, 32'h0);
    cyc(32'h3000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'hFFFF);
    check("err2_hready", {31'h0, HREADY_M}, 32'h1);
    check("err2_hresp", {31'h0, HRESP_M}, 32'h1);
    check("err2_saddrsel", {16'h0, SADDRSEL}, 32'h0008);
    check("err2_sdatasel", {16'h0, SDATASEL}, 32'h0);
    cyc(32'h0000_0000, HTRANS_IDLE, 16'hFFFF, 16'hFFFF);
    check("err_next_hresp", {31'h0, HRESP_M}, 32'h0);
    check("err_next_sdatasel", {16'h0, SDATASEL}, 32'h0008);

    // Back-to-back: slot 1 data phase stalls two cycles while slot 2 address waits.
    cyc(32'h1000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'hFFFF);
    check("b2b_c0_saddrsel", {16'h0, SADDRSEL}, 32'h0002);
    for (int c = 1; c <= 2; c++) begin
      cyc(32'h2000_0000, HTRANS_NONSEQ, 16'hFFFF, ~16'h0002);
      check($sformatf("b2b_c%0d_hready", c), {31'h0, HREADY_M}, 32'h0);
      check($sformatf("b2b_c%0d_saddrsel", c), {16'h0, SADDRSEL}, 32'h0);
      check($sformatf("b2b_c%0d_sdatasel", c), {16'h0, SDATASEL}, 32'h0002);
      check($sformatf("b2b_c%0d_gaddr", c), GATEDHADDR, 32'h2000_0000);
    end
    cyc(32'h2000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'hFFFF);
    check("b2b_c3_hready", {31'h0, HREADY_M}, 32'h1);
    check("b2b_c3_saddrsel", {16'h0, SADDRSEL}, 32'h0004);
    check("b2b_c3_sdatasel", {16'h0, SDATASEL}, 32'h0002);
    cyc(32'h0000_0000, HTRANS_IDLE, 16'hFFFF, 16'hFFFF);
    check("b2b_c4_sdatasel", {16'h0, SDATASEL}, 32'h0004);
    check("b2b_c4_hrdata", HRDATA_M, pat(2));

    // Reset while held discards the parked address.
    cyc(32'h5000_0000, HTRANS_NONSEQ, ~16'h0020, 16'hFFFF);
    check("rsth_c0_saddrsel", {16'h0, SADDRSEL}, 32'h0020);
    cyc(32'h7000_0000, HTRANS_IDLE, 16'hFFFF, 16'hFFFF);
    check("rsth_c1_hready", {31'h0, HREADY_M}, 32'h0);
    HRESETN = 1'b0;
    #1;
    check("rsth_c1_saddrsel", {16'h0, SADDRSEL}, 32'h0);
    @(negedge HCLK);
    HRESETN = 1'b1;
    #2;
    check("rsth_hready", {31'h0, HREADY_M}, 32'h1);
    check("rsth_hresp", {31'h0, HRESP_M}, 32'h0);
    check("rsth_saddrsel", {16'h0, SADDRSEL}, 32'h0);
    check("rsth_sdatasel", {16'h0, SDATASEL}, 32'h0);
    check("rsth_gaddr", GATEDHADDR, 32'h7000_0000);
    cyc(32'h7000_0000, HTRANS_IDLE, 16'hFFFF, 16'hFFFF);
    check("rsth_next_sdatasel", {16'h0, SDATASEL}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
